nand_gate_sweeper: RTL and testbench

Self-checking stimulus stage that sits directly upstream of the NAND-built basic-gates block. On a start request it drives the two gate inputs A and B through all four combinations, waits a programmable settle time, samples the six gate outputs and compares each against its ideal truth-table value. It reports a pass flag, a per-output fail mask and a per-combination fail vector, then returns to idle.

---
 rtl/nand_gate_sweeper.sv | 178 +++++++++++++++++
 tb/tb_nand_gate_sweeper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_sweeper.sv
// Exhaustive two-input sweeper for the NAND-built basic-gates block: drives A/B through
// all four combinations, samples the six gate outputs after a settle time, and reports results.
module nand_gate_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    input  logic       not_in,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_mask,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] combo_q, combo_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] fail_mask_q, fail_mask_d;
    logic [3:0] fail_vec_q, fail_vec_d;

    logic       exp_a, exp_b;
    logic [5:0] mism;

    // Expected values come from the combination register, not from the driven pins.
    always_comb begin
        exp_a   = combo_q[1];
        exp_b   = combo_q[0];
        mism[0] = and_in  ^ (exp_a & exp_b);
        mism[1] = or_in   ^ (exp_a | exp_b);
        mism[2] = xor_in  ^ (exp_a ^ exp_b);
        mism[3] = xnor_in ^ ~(exp_a ^ exp_b);
        mism[4] = not_in  ^ ~exp_a;
        mism[5] = ~y_in;
    end

    always_comb begin
        state_d     = state_q;
        combo_d     = combo_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_vec_d  = fail_vec_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = DRIVE;
                    combo_d     = 2'd0;
                    cnt_d       = 4'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_mask_d = 6'd0;
                    fail_vec_d  = 4'd0;
                end
            end

            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    combo_d = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // An aborted sample cycle leaves the sticky results untouched.
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    combo_d = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    fail_mask_d = fail_mask_q | mism;
                    if (|mism) begin
                        fail_vec_d[combo_q] = 1'b1;
                    end
                    if (combo_q == 2'd3) begin
                        state_d = DONE;
                        combo_d = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ~|(fail_mask_q | mism);
                    end else begin
                        state_d = DRIVE;
                        combo_d = combo_q + 2'd1;
                        a_d     = combo_d[1];
                        b_d     = combo_d[0];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            combo_q     <= 2'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 6'd0;
            fail_vec_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            combo_q     <= combo_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// Bench for nand_gate_sweeper: a fault-injectable ideal gates model feeds a SETTLE=2 instance,
// and a second SETTLE=1 instance with ideal gates covers the short-settle timing.
module tb_nand_gate_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic       and_in, or_in, xor_in, xnor_in, not_in, y_in;
    logic       a_out, b_out, busy, done, pass;
    logic [5:0] fail_mask;
    logic [3:0] fail_vec;
    logic       or_stuck0, y_stuck0, xor_inv;

    logic       start1, abort1;
    logic       and1, or1, xor1, xnor1, not1, y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [5:0] mask1;
    logic [3:0] vec1;

    int passCount = 0;
    int checkCount = 0;

    nand_gate_sweeper #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .and_in(and_in), .or_in(or_in), .xor_in(xor_in), .xnor_in(xnor_in),
        .not_in(not_in), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .fail_vec(fail_vec)
    );

    nand_gate_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .and_in(and1), .or_in(or1), .xor_in(xor1), .xnor_in(xnor1),
        .not_in(not1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .fail_vec(vec1)
    );

    // Ideal gates with optional faults, driven from the sweeper's own A/B pins.
    always_comb begin
        and_in  = a_out & b_out;
        or_in   = (a_out | b_out) & ~or_stuck0;
        xor_in  = (a_out ^ b_out) ^ xor_inv;
        xnor_in = ~(a_out ^ b_out);
        not_in  = ~a_out;
        y_in    = ~y_stuck0;
        and1    = a1 & b1;
        or1     = a1 | b1;
        xor1    = a1 ^ b1;
        xnor1   = ~(a1 ^ b1);
        not1    = ~a1;
        y1      = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Runs one full SETTLE=2 sweep with the given fault set and checks timing and results.
    task automatic applyStimulus(input string tag, input logic [2:0] fault, input logic expPass,
                                 input logic [5:0] expMask, input logic [3:0] expVec);
        int latency;
        int seqErr;
        logic [1:0] expAb;
        {xor_inv, y_stuck0, or_stuck0} = fault;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, " busy_at_accept"}, 32'(busy), 32'd1);
        checkOutput({tag, " cleared_at_accept"}, {21'd0, pass, fail_mask, fail_vec}, 32'd0);
        latency = 0;
        seqErr  = 0;
        for (int m = 0; m < 40 && latency == 0; m++) begin
            expAb = 2'(m / 3);
            if (m < 12 && {a_out, b_out} !== expAb) seqErr++;
            if (done) latency = m;
            else @(posedge clk) #1;
        end
        checkOutput({tag, " done_latency"}, 32'(latency), 32'd12);
        checkOutput({tag, " ab_sequence_errors"}, 32'(seqErr), 32'd0);
        checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, " pass"}, 32'(pass), 32'(expPass));
        checkOutput({tag, " fail_mask"}, 32'(fail_mask), 32'(expMask));
        checkOutput({tag, " fail_vec"}, 32'(fail_vec), 32'(expVec));
        @(posedge clk); #1;
        checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, " results_held"}, {22'd0, fail_mask, fail_vec}, {22'd0, expMask, expVec});
    endtask

    typedef struct {
        string      tag;
        logic [2:0] fault;
        logic       expPass;
        logic [5:0] expMask;
        logic [3:0] expVec;
    } vec_t;

    vec_t vectors[4];

    initial begin
        int doneCnt;
        int lat;
        int busyErr;

        vectors[0] = '{"ideal",      3'b000, 1'b1, 6'b000000, 4'b0000};
        vectors[1] = '{"or_stuck0",  3'b001, 1'b0, 6'b000010, 4'b1110};
        vectors[2] = '{"y_stuck0",   3'b010, 1'b0, 6'b100000, 4'b1111};
        vectors[3] = '{"ideal_again",3'b000, 1'b1, 6'b000000, 4'b0000};

        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        or_stuck0 = 1'b0; y_stuck0 = 1'b0; xor_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {20'd0, a_out, b_out, busy, done, pass, fail_mask, fail_vec}, 32'd0);
        checkOutput("reset_outputs_s1", {20'd0, a1, b1, busy1, done1, pass1, mask1, vec1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].tag, vectors[i].fault, vectors[i].expPass,
                          vectors[i].expMask, vectors[i].expVec);
            @(posedge clk); #1;
        end

        // Abort during combination 2 with XOR inverted.
        {xor_inv, y_stuck0, or_stuck0} = 3'b100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort combo2_driven", 32'({a_out, b_out}), 32'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ab", 32'({a_out, b_out}), 32'd0);
        checkOutput("abort pass", 32'(pass), 32'd0);
        checkOutput("abort fail_mask", 32'(fail_mask), 32'b000100);
        checkOutput("abort fail_vec", 32'(fail_vec), 32'b0011);
        doneCnt = 0;
        for (int m = 0; m < 20; m++) begin
            if (done) doneCnt++;
            @(posedge clk); #1;
        end
        checkOutput("abort no_done", 32'(doneCnt), 32'd0);

        // Reset while driving combination 2 of an OR-faulted sweep.
        {xor_inv, y_stuck0, or_stuck0} = 3'b001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre_reset busy", 32'(busy), 32'd1);
        checkOutput("pre_reset fail_mask", 32'(fail_mask), 32'b000010);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset outputs", {20'd0, a_out, b_out, busy, done, pass, fail_mask, fail_vec}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus("after_reset", 3'b000, 1'b1, 6'b000000, 4'b0000);
        @(posedge clk); #1;

        // Simultaneous start and abort in IDLE must not begin a sweep.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        busyErr = 0;
        for (int m = 0; m < 4; m++) begin
            if (busy) busyErr++;
            @(posedge clk); #1;
        end
        checkOutput("start_abort no_busy", 32'(busyErr), 32'd0);
        checkOutput("start_abort results_held", 32'(pass), 32'd1);

        // SETTLE=1: eight-cycle sweep, and a second start three cycles in is ignored.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        checkOutput("s1 busy_at_accept", 32'(busy1), 32'd1);
        doneCnt = 0;
        lat = 0;
        for (int m = 1; m <= 30; m++) begin
            if (m == 3) start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            if (done1) begin
                doneCnt++;
                if (lat == 0) lat = m;
            end
        end
        checkOutput("s1 done_latency", 32'(lat), 32'd8);
        checkOutput("s1 done_count", 32'(doneCnt), 32'd1);
        checkOutput("s1 pass", 32'(pass1), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
